// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pkg
// Description : Shared fetch-stage types and field widths for IF/ID and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int INSTR_W      = 16;
    localparam int IMM_FLAG_BIT = 2;

    typedef enum logic [0:0] {
        S_INSTR = 1'b0,
        S_IMM   = 1'b1
    } fetch_state_e;

    function automatic logic has_imm_flag(input logic [INSTR_W-1:0] word, input int flag_bit);
        return word[flag_bit];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_register.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_pc_register
// Description : Program counter with load / increment / hold select.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer_pc_register #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_load_val,
    output logic [PC_W-1:0] o_pc
);

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] r_pc;

    // Load wins over increment; wrap past all-ones is plain modulo arithmetic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + c_PC_ONE;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch front end assembling 16-bit or 32-bit fetch packets.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              IMM_BIT  = IMM_FLAG_BIT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [INSTR_W-1:0] out_imm,
    output logic               out_has_imm,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_next
);

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] c_PC_TWO = {{(PC_W-2){1'b0}}, 2'b10};

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [PC_W-1:0]    w_pc;
    logic               w_pc_inc;
    logic               w_imm_flag;

    logic [INSTR_W-1:0] r_hold_instr, w_hold_instr_next;
    logic [PC_W-1:0]    r_hold_pc, w_hold_pc_next;
    logic               r_valid, w_valid_next;
    logic [INSTR_W-1:0] r_instr, w_instr_next;
    logic [INSTR_W-1:0] r_imm, w_imm_next;
    logic               r_has_imm, w_has_imm_next;
    logic [PC_W-1:0]    r_pc_out, w_pc_out_next;
    logic [PC_W-1:0]    r_pc_next, w_pc_next_next;

    assign w_pc_inc   = !redirect && !stall;
    assign w_imm_flag = has_imm_flag(imem_data, IMM_BIT);

    fetch_sequencer_pc_register #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .rst        (rst),
        .i_load     (redirect),
        .i_inc      (w_pc_inc),
        .i_load_val (redirect_pc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INSTR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            w_state_next = S_INSTR;
        end else if (!stall) begin
            if (r_state == S_INSTR) begin
                w_state_next = w_imm_flag ? S_IMM : S_INSTR;
            end else begin
                w_state_next = S_INSTR;
            end
        end
    end

    // Redirect only clears valid; the held half-instruction is dropped by the state return.
    always_comb begin
        w_valid_next      = r_valid;
        w_instr_next      = r_instr;
        w_imm_next        = r_imm;
        w_has_imm_next    = r_has_imm;
        w_pc_out_next     = r_pc_out;
        w_pc_next_next    = r_pc_next;
        w_hold_instr_next = r_hold_instr;
        w_hold_pc_next    = r_hold_pc;
        if (redirect) begin
            w_valid_next = 1'b0;
        end else if (!stall) begin
            if (r_state == S_INSTR) begin
                if (w_imm_flag) begin
                    w_hold_instr_next = imem_data;
                    w_hold_pc_next    = w_pc;
                    w_valid_next      = 1'b0;
                end else begin
                    w_valid_next   = 1'b1;
                    w_instr_next   = imem_data;
                    w_imm_next     = '0;
                    w_has_imm_next = 1'b0;
                    w_pc_out_next  = w_pc;
                    w_pc_next_next = w_pc + c_PC_ONE;
                end
            end else begin
                w_valid_next   = 1'b1;
                w_instr_next   = r_hold_instr;
                w_imm_next     = imem_data;
                w_has_imm_next = 1'b1;
                w_pc_out_next  = r_hold_pc;
                w_pc_next_next = r_hold_pc + c_PC_TWO;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_imm        <= '0;
            r_has_imm    <= 1'b0;
            r_pc_out     <= '0;
            r_pc_next    <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            r_valid      <= w_valid_next;
            r_instr      <= w_instr_next;
            r_imm        <= w_imm_next;
            r_has_imm    <= w_has_imm_next;
            r_pc_out     <= w_pc_out_next;
            r_pc_next    <= w_pc_next_next;
            r_hold_instr <= w_hold_instr_next;
            r_hold_pc    <= w_hold_pc_next;
        end
    end

    assign imem_addr   = w_pc;
    assign out_valid   = r_valid;
    assign out_instr   = r_instr;
    assign out_imm     = r_imm;
    assign out_has_imm = r_has_imm;
    assign out_pc      = r_pc_out;
    assign out_pc_next = r_pc_next;

endmodule
`default_nettype wire
